mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-port memory between the instruction-fetch (IF) port and the load/store (LS) port of the multi-cycle core, so that IMEM and DMEM can live in one array. The arbiter uses a request/grant handshake with round-robin priority on ties. It drives the memory for one cycle per access and returns read data after a fixed memory latency. Writes complete in the grant cycle; reads hold the memory until their data returns.

## Interface
- MEM_LAT, 2: cycles from the `mem_en` read cycle to valid `mem_rdata`; legal range 1..7.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous reset, active-low (asserted = 0).
- if_req  in  1  IF read request; held with `if_addr` until `if_gnt`.
- if_addr  in  32  IF word address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  `if_rdata` valid this cycle.
- if_rdata  out  32  IF read data; 0 when `if_rvalid` = 0.
- ls_req  in  1  LS request; held with `ls_we`, `ls_addr` and `ls_wdata` until `ls_gnt`.
- ls_we  in  1  1 = write, 0 = read.
- ls_addr  in  32  LS address.
- ls_wdata  in  32  LS write data.
- ls_gnt  out  1  LS request accepted this cycle.
- ls_rvalid  out  1  `ls_rdata` valid this cycle.
- ls_rdata  out  32  LS read data; 0 when `ls_rvalid` = 0.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write strobe (qualified by `mem_en`).
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after a read `mem_en`.

## Operation
- **State machine:** IDLE, WAIT, RESP.
- **Registered state:**
  - `owner` (0 = IF, 1 = LS).
  - `last` (0 = IF, 1 = LS): the port that was granted most recently.
  - 3-bit counter `cnt`.
- **IDLE, no request:** all grants and `mem_*` outputs are 0.
- **IDLE, one request:** the requester wins.
- **IDLE, both requests:** the winner is the port not equal to `last`.
- **Grant cycle (combinational from IDLE and the requests):**
  - Winner's `gnt` = 1 and `mem_en` = 1.
  - `mem_addr`, `mem_we` and `mem_wdata` are taken from the winner.
  - IF is always a read; `mem_wdata` = 0 for IF.
  - `last` <= winner.
- **LS write grant:** completes in the grant cycle. The state stays IDLE and no rvalid is produced.
- **Read grant:**
  - `owner` <= winner.
  - If MEM_LAT = 1: next state RESP.
  - Else: next state WAIT with `cnt` <= MEM_LAT-1.
- **WAIT:**
  - `cnt` decrements each cycle; at `cnt` = 1 the next state is RESP.
  - No grants and `mem_en` = 0.
- **RESP:**
  - The owner's `rvalid` = 1 and its `rdata` = `mem_rdata` (combinational pass-through).
  - No grants. Next state IDLE.
- **Outside IDLE:** requests are ignored (`gnt` = 0). Requesters keep holding them.
- **Reset values (while reset = 0):**
  - State IDLE, `owner` 0, `last` 0 (IF), `cnt` 0.
  - All outputs 0; requests are ignored.
- **Reset mid-access:** a read in WAIT or RESP is dropped. No rvalid follows reset deassertion.
- **Reset release with both ports requesting:** LS wins the first tie, because `last` = IF.

## Timing
- **Read:**
  - Grant at cycle T.
  - `mem_rdata` sampled and rvalid at T+MEM_LAT.
  - Earliest next grant at T+MEM_LAT+1.
- **Write:** grant at T; next grant possible at T+1, so back-to-back writes run at one per cycle.
- **Under continuous contention:** grants alternate strictly IF/LS.
- **Combinational paths:**
  - `gnt`, `mem_en`, `mem_addr`, `mem_we`, `mem_wdata` depend only on state and the request inputs.
  - `rdata` depends only on state, `owner` and `mem_rdata`.
- **No path** from `mem_rdata` to any grant.
- **Cycle-level invariants:**
  - At most one `gnt` is high per cycle.
  - At most one `rvalid` is high per cycle.
  - `rvalid` and `gnt` are never high in the same cycle.

## Test plan
- **Single IF read, MEM_LAT=2:** reset released, `if_req`=1 with `if_addr`=0x10 at T.
  - T: `if_gnt`=1, `mem_en`=1, `mem_addr`=0x10, `mem_we`=0.
  - T+2: memory returns 0xDEADBEEF; `if_rvalid`=1 and `if_rdata`=0xDEADBEEF.
  - `if_gnt`=0 at T+1 and T+2.
- **Tie after reset:** `if_req` and `ls_req` (read, 0x20) both high at T.
  - T: `ls_gnt`=1, `if_gnt`=0.
  - T+2: `ls_rvalid`.
  - T+3: `if_gnt`=1.
- **Back-to-back writes:** `ls_we`=1, addresses 0x40, 0x44, 0x48 on consecutive cycles.
  - `ls_gnt`=1 three consecutive cycles; `mem_we`=1 each with the matching address and data.
  - No `ls_rvalid`.
- **Continuous contention, LS issuing writes, IF issuing reads:** grant sequence LS, IF, LS, IF.
  - Each IF read blocks grants for MEM_LAT cycles.
  - No cycle has two grants.
- **Reset mid-read:** read granted at T; reset asserted at T+1 and released at T+3.
  - No rvalid at any cycle.
  - All outputs 0 during reset.
  - A new `if_req` is granted on the first cycle after release.
- **MEM_LAT=1 build:** IF read granted at T; `if_rvalid` at T+1; next grant possible at T+2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one single-port memory between the instruction-fetch (IF) port and
// the load/store (LS) port. Requests use a request/grant handshake. Ties are
// broken round-robin against the most recently granted port.
//
// Writes complete in their grant cycle. A read holds the memory until its
// data comes back MEM_LAT cycles after the grant.
//
// Ports
//   clk, reset            clock and asynchronous active-low reset
//   if_req/if_addr        IF read request, held until if_gnt
//   if_gnt                IF request accepted this cycle
//   if_rvalid/if_rdata    IF read response (rdata is 0 when not valid)
//   ls_req/ls_we/ls_addr/ls_wdata
//                         LS request, held until ls_gnt
//   ls_gnt                LS request accepted this cycle
//   ls_rvalid/ls_rdata    LS read response (rdata is 0 when not valid)
//   mem_en/mem_we/mem_addr/mem_wdata
//                         memory command, driven only in a grant cycle
//   mem_rdata             memory read data, valid MEM_LAT cycles after a read
//
// Parameter
//   MEM_LAT               read latency in cycles, legal range 1..7
module mem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Port encoding used by owner_reg and last_reg.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    state_t     state_reg;
    logic       owner_reg;
    logic       last_reg;
    logic [2:0] cnt_reg;

    logic can_grant;
    logic if_win;
    logic ls_win;
    logic resp;

    // Grants are also masked by reset itself: reset is asynchronous, so a
    // request present while reset is held must not leak through the
    // combinational grant path.
    assign can_grant = (state_reg == IDLE) && reset;

    // On a tie the port that was not granted last wins.
    assign if_win = can_grant && if_req && (!ls_req || (last_reg == PORT_LS));
    assign ls_win = can_grant && ls_req && (!if_req || (last_reg == PORT_IF));

    assign if_gnt    = if_win;
    assign ls_gnt    = ls_win;
    assign mem_en    = if_win || ls_win;
    assign mem_we    = ls_win && ls_we;
    assign mem_addr  = if_win ? if_addr : (ls_win ? ls_addr : 32'd0);
    assign mem_wdata = ls_win ? ls_wdata : 32'd0;

    // Read data is a straight pass-through from memory in the response cycle.
    assign resp      = (state_reg == RESP);
    assign if_rvalid = resp && (owner_reg == PORT_IF);
    assign ls_rvalid = resp && (owner_reg == PORT_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            owner_reg <= PORT_IF;
            last_reg  <= PORT_IF;
            cnt_reg   <= 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (if_win || ls_win) begin
                        last_reg <= ls_win ? PORT_LS : PORT_IF;
                        // An LS write is finished in its grant cycle; only
                        // reads occupy the memory until data returns.
                        if (if_win || !ls_we) begin
                            owner_reg <= ls_win ? PORT_LS : PORT_IF;
                            if (MEM_LAT == 1) begin
                                state_reg <= RESP;
                            end else begin
                                state_reg <= WAIT;
                                cnt_reg   <= CNT_INIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
